trigger_capture_ctrl: RTL and testbench
=======================================

Name: trigger_capture_ctrl

Overview:
- Front-end capture stage between the ADC data pins and the sample FIFO, which the UART sender drains.
- Decimates the 8-bit ADC stream and arms on request.
- Detects a level crossing (rising or falling), or accepts a forced trigger, then writes exactly CAPTURE_LEN samples into the FIFO.
- Reports Busy/Triggered/Done and a sticky Overflow if the FIFO was full during capture.

Parameters:
- DATA_W, 8, ADC sample width.
- CAPTURE_LEN, 256, samples written per capture, including the trigger sample; must be >= 1.
- DECIM_W, 16, width of the decimation control.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- I_AD_Data  input  DATA_W  ADC sample, valid every cycle.
- Trig_Level  input  DATA_W  trigger threshold (unsigned).
- Trig_Edge  input  1  0 = rising, 1 = falling.
- Decim  input  DECIM_W  a sample strobe fires every Decim+1 clocks.
- Arm  input  1  single-cycle request to start a capture.
- Force  input  1  single-cycle forced trigger, honoured only while ARMED.
- Fifo_Full  input  1  FIFO full flag.
- Fifo_Wr_En  output  1  FIFO write strobe.
- Fifo_Wr_Data  output  DATA_W  FIFO write data.
- Busy  output  1  high in ARMED or CAPTURE.
- Triggered  output  1  high in CAPTURE.
- Done  output  1  one-cycle pulse when a capture completes.
- Overflow  output  1  sticky; a sample was dropped because Fifo_Full was high.

Behaviour:
- Reset: state IDLE, decimation counter 0, prev_valid 0, sample count 0. All outputs are 0, including Fifo_Wr_Data.
- Decimation counter runs in every state.
  - strobe = (cnt >= Decim); on strobe cnt <= 0, otherwise cnt <= cnt+1.
  - Decim = 0 gives a strobe every cycle.
  - Lowering Decim below the current cnt gives a strobe on the next cycle; there is no 2^DECIM_W wrap.
- prev register holds I_AD_Data from the last strobe. prev_valid clears on entry to ARMED and sets at the first strobe in ARMED.
- Crossing is evaluated only at a strobe with prev_valid = 1:
  - rising: prev < Trig_Level and I_AD_Data >= Trig_Level.
  - falling: prev > Trig_Level and I_AD_Data <= Trig_Level.
  - Comparisons are unsigned.
- IDLE:
  - Arm -> ARMED. On that transition Overflow clears and prev_valid clears.
  - Force is ignored.
- ARMED:
  - At a strobe with a crossing, or with Force seen at or since the last strobe (Force is latched until the next strobe): the current I_AD_Data is the trigger sample.
  - The trigger sample is written as sample 0 and the state goes to CAPTURE.
  - Arm is ignored.
- CAPTURE:
  - Each strobe writes the current I_AD_Data.
  - After the write that makes the count equal CAPTURE_LEN, the state goes to DONE.
  - Arm and Force are ignored.
- DONE: one cycle with Done = 1, then IDLE.
- Write timing:
  - Fifo_Wr_En and Fifo_Wr_Data are registered and appear one clock after the strobe cycle, carrying the I_AD_Data sampled at that strobe.
  - Fifo_Wr_Data holds its last value when Fifo_Wr_En = 0.
- Full handling:
  - If Fifo_Full = 1 at a write strobe, no write occurs and Overflow sets.
  - The sample count still advances, so the capture spans a fixed time window.
  - Fifo_Full is sampled in the strobe cycle.
- CAPTURE_LEN = 1: the trigger write is the only write; ARMED goes directly to DONE.
- Trigger and Arm in the same cycle are not possible, since a trigger needs ARMED.
- Reset asserted mid-capture: next cycle is IDLE and Fifo_Wr_En = 0. Already-written samples stay in the FIFO; clearing it is the FIFO owner's job.
- Done is asserted one cycle after the final Fifo_Wr_En cycle when Decim = 0. In general Done is registered from the same edge as the last write decision, so it coincides with the last write strobe's output cycle + 1.

Test Plan:
- Rising trigger: Decim=0, CAPTURE_LEN=4, Trig_Level=100, Arm, then I_AD_Data 50, 150, 75, 25, 200. Required response:
  - exactly 4 writes: 150, 75, 25, 200;
  - then one Done pulse;
  - Busy low afterwards.
- No trigger / first-sample gating: Arm, then I_AD_Data constant 150. Required response: no write, stays ARMED. Then 50 followed by 150 triggers, and the first written value is 150.
- Falling edge plus decimation: Trig_Edge=1, Decim=3, level 100, ramp 200 down to 0 in steps of 10 per clock. Required response:
  - writes spaced exactly 4 clocks apart;
  - first written sample <= 100 and the prior strobe sample > 100.
- Force: Arm, hold I_AD_Data=50 (no crossing), pulse Force between strobes with Decim=7. Required response: capture starts at the next strobe, with the first write 1 clock after that strobe.
- FIFO full: CAPTURE_LEN=8, Fifo_Full held high for strobes 3-4. Required response:
  - 6 writes;
  - Overflow = 1 after the first dropped sample and staying 1 through Done;
  - Overflow cleared by the next Arm.
- Reset mid-capture: Reset for 1 cycle after 2 writes of an 8-sample capture. Required response:
  - all outputs 0 on the next cycle;
  - no Done;
  - a following Arm plus trigger gives a full 8-sample capture.

Source files
------------

// File: rtl/trigger_capture_ctrl.sv
// trigger_capture_ctrl: decimating ADC front end that arms, triggers on a level crossing or force, and writes a fixed-length capture into a FIFO.
//   clk, rst           : clock (rising edge), synchronous active-high reset
//   ad_data            : ADC sample, valid every cycle
//   trig_level         : unsigned trigger threshold
//   trig_edge          : 0 = rising crossing, 1 = falling crossing
//   decim              : a sample strobe fires every decim+1 clocks
//   arm, force_trig    : single-cycle capture request / forced trigger (ARMED only)
//   fifo_full          : FIFO full flag, sampled in the strobe cycle
//   fifo_wr_en/_data   : registered FIFO write port, data holds when idle
//   busy, triggered    : ARMED or CAPTURE / CAPTURE
//   done               : one-cycle pulse after the last write decision
//   overflow           : sticky, a write was dropped on a full FIFO; cleared by arm
module trigger_capture_ctrl #(
    parameter int DATA_W      = 8,
    parameter int CAPTURE_LEN = 256,
    parameter int DECIM_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ad_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic [DECIM_W-1:0] decim,
    input  logic              arm,
    input  logic              force_trig,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic              overflow
);
    localparam int CNT_W = $clog2(CAPTURE_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [DECIM_W-1:0] dcnt;
    logic [DATA_W-1:0]  prev;
    logic               prev_valid, force_pend;
    logic [CNT_W-1:0]   count;
    logic               strobe, crossing, trig, wr_cmd, last;

    // >= rather than == so lowering decim below the running count strobes at once
    assign strobe   = dcnt >= decim;
    assign crossing = prev_valid && (trig_edge ? (prev > trig_level && ad_data <= trig_level)
                                               : (prev < trig_level && ad_data >= trig_level));
    assign trig     = state == S_ARMED && strobe && (crossing || force_trig || force_pend);
    assign wr_cmd   = trig || (state == S_CAPTURE && strobe);
    assign last     = (count + CNT_W'(1)) == CNT_W'(CAPTURE_LEN);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (arm) state_nxt = S_ARMED;
            S_ARMED:   if (trig) state_nxt = CAPTURE_LEN == 1 ? S_DONE : S_CAPTURE;
            S_CAPTURE: if (strobe && last) state_nxt = S_DONE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = state == S_ARMED || state == S_CAPTURE;
        triggered = state == S_CAPTURE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt         <= '0;
            prev         <= '0;
            prev_valid   <= 1'b0;
            force_pend   <= 1'b0;
            count        <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            done         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            dcnt <= strobe ? '0 : dcnt + DECIM_W'(1);
            if (strobe) prev <= ad_data;
            // a fresh arm must not compare against a sample taken before arming
            if (state == S_IDLE && arm) prev_valid <= 1'b0;
            else if (state == S_ARMED && strobe) prev_valid <= 1'b1;
            // force between strobes waits for the next strobe to pick its sample
            force_pend <= state == S_ARMED && !strobe && (force_pend || force_trig);
            if (trig) count <= CNT_W'(1);
            else if (state == S_CAPTURE && strobe) count <= count + CNT_W'(1);
            fifo_wr_en <= wr_cmd && !fifo_full;
            if (wr_cmd && !fifo_full) fifo_wr_data <= ad_data;
            done <= state == S_DONE;
            if (state == S_IDLE && arm) overflow <= 1'b0;
            else if (wr_cmd && fifo_full) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// tb_trigger_capture_ctrl: scoreboard bench for trigger_capture_ctrl with capture lengths 4, 8 and 1.
module tb_trigger_capture_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ad_data = 8'd0;
    logic [7:0]  trig_level = 8'd100;
    logic        trig_edge = 1'b0;
    logic [15:0] decim = 16'd0;
    logic        arm = 1'b0;
    logic        force_trig = 1'b0;
    logic        fifo_full = 1'b0;
    logic [2:0]  we, bz, tg, dn, ov;
    logic [7:0]  wd0, wd1, wd2, wd_sel;

    int checks = 0, errors = 0, cyc = 0, sel = 0, done_cnt = 0, done_t = 0;
    int obs_q[$], obs_t[$], exp_q[$];

    trigger_capture_ctrl #(.CAPTURE_LEN(4)) dut4 (.clk(clk), .rst(rst), .ad_data(ad_data), .trig_level(trig_level),
        .trig_edge(trig_edge), .decim(decim), .arm(arm), .force_trig(force_trig), .fifo_full(fifo_full),
        .fifo_wr_en(we[0]), .fifo_wr_data(wd0), .busy(bz[0]), .triggered(tg[0]), .done(dn[0]), .overflow(ov[0]));
    trigger_capture_ctrl #(.CAPTURE_LEN(8)) dut8 (.clk(clk), .rst(rst), .ad_data(ad_data), .trig_level(trig_level),
        .trig_edge(trig_edge), .decim(decim), .arm(arm), .force_trig(force_trig), .fifo_full(fifo_full),
        .fifo_wr_en(we[1]), .fifo_wr_data(wd1), .busy(bz[1]), .triggered(tg[1]), .done(dn[1]), .overflow(ov[1]));
    trigger_capture_ctrl #(.CAPTURE_LEN(1)) dut1 (.clk(clk), .rst(rst), .ad_data(ad_data), .trig_level(trig_level),
        .trig_edge(trig_edge), .decim(decim), .arm(arm), .force_trig(force_trig), .fifo_full(fifo_full),
        .fifo_wr_en(we[2]), .fifo_wr_data(wd2), .busy(bz[2]), .triggered(tg[2]), .done(dn[2]), .overflow(ov[2]));

    assign wd_sel = sel == 0 ? wd0 : sel == 1 ? wd1 : wd2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we[sel]) begin
            obs_q.push_back(int'(wd_sel));
            obs_t.push_back(cyc);
        end
        if (dn[sel]) begin
            done_cnt++;
            done_t = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_t.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        arm = 1'b0;
        force_trig = 1'b0;
        fifo_full = 1'b0;
        tick();
        rst = 1'b0;
        clear_obs();
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1;
        rst = 1'b1;
        ad_data = 8'hAA;
        arm = 1'b1;
        tick();
        tick();
        arm = 1'b0;
        rst = 1'b0;
        checks++;
        if ({we, bz, tg, dn, ov} !== 15'd0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0", {we, bz, tg, dn, ov});
        end
        checks++;
        if ({wd0, wd1, wd2} !== 24'd0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {wd0, wd1, wd2});
        end
    endtask

    task automatic test_rising();
        int seq[5] = '{50, 150, 75, 25, 200};
        int prevv = -1;
        bit tr = 0;
        int n = 0, first_t, last_t, o, e;
        sel = 0;
        decim = 0;
        trig_edge = 0;
        trig_level = 100;
        ad_data = 0;
        do_reset();
        do_arm();
        checks++;
        if (bz[0] !== 1'b1) begin
            errors++;
            $display("FAIL rising_busy_armed: got %b expected 1", bz[0]);
        end
        for (int i = 0; i < 5; i++) begin
            ad_data = 8'(seq[i]);
            if (!tr && prevv >= 0 && prevv < 100 && seq[i] >= 100) tr = 1;
            if (tr && n < 4) begin
                exp_q.push_back(seq[i]);
                n++;
            end
            prevv = seq[i];
            tick();
        end
        ad_data = 0;
        repeat (4) tick();
        checks++;
        if (obs_q.size() !== 4) begin
            errors++;
            $display("FAIL rising_count: got %0d expected 4", obs_q.size());
        end
        first_t = obs_t.size() > 0 ? obs_t[0] : 0;
        last_t = obs_t.size() > 0 ? obs_t[$] : 0;
        checks++;
        if (last_t - first_t !== 3) begin
            errors++;
            $display("FAIL rising_contiguous: got span %0d expected 3", last_t - first_t);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rising_data: got %0d expected %0d", o, e);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_t !== last_t + 1) begin
            errors++;
            $display("FAIL rising_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_t, last_t + 1);
        end
        checks++;
        if (bz[0] !== 1'b0) begin
            errors++;
            $display("FAIL rising_busy_after: got %b expected 0", bz[0]);
        end
    endtask

    task automatic test_no_trigger();
        int o, e;
        sel = 1;
        decim = 0;
        trig_edge = 0;
        trig_level = 100;
        do_reset();
        do_arm();
        ad_data = 150;
        repeat (10) tick();
        checks++;
        if (obs_q.size() !== 0 || bz[1] !== 1'b1 || tg[1] !== 1'b0) begin
            errors++;
            $display("FAIL notrig_hold: got writes=%0d busy=%b trig=%b expected 0,1,0", obs_q.size(), bz[1], tg[1]);
        end
        ad_data = 50;
        tick();
        ad_data = 150;
        exp_q.push_back(150);
        tick();
        for (int i = 1; i < 8; i++) begin
            ad_data = 8'(10 * i);
            exp_q.push_back(10 * i);
            tick();
        end
        repeat (3) tick();
        checks++;
        if (obs_q.size() !== 8) begin
            errors++;
            $display("FAIL notrig_count: got %0d expected 8", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL notrig_data: got %0d expected %0d", o, e);
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL notrig_done: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_falling_decim();
        int v, prevs = 0, n = 0, o, e;
        bit have_prev = 0, tr = 0;
        sel = 1;
        decim = 3;
        trig_edge = 1;
        trig_level = 100;
        ad_data = 0;
        do_reset();
        do_arm();
        for (int k = 1; k <= 44; k++) begin
            v = 200 - 10 * (k - 1);
            if (v < 0) v = 0;
            ad_data = 8'(v);
            if (k % 4 == 3) begin
                if (!tr && have_prev && prevs > 100 && v <= 100) tr = 1;
                if (tr && n < 8) begin
                    exp_q.push_back(v);
                    n++;
                end
                prevs = v;
                have_prev = 1;
            end
            tick();
        end
        checks++;
        if (obs_q.size() !== 8) begin
            errors++;
            $display("FAIL falling_count: got %0d expected 8", obs_q.size());
        end
        for (int i = 1; i < obs_t.size(); i++) begin
            checks++;
            if (obs_t[i] - obs_t[i-1] !== 4) begin
                errors++;
                $display("FAIL falling_spacing: got %0d expected 4", obs_t[i] - obs_t[i-1]);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL falling_data: got %0d expected %0d", o, e);
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL falling_done: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_force();
        int r, first_t, last_t, o;
        sel = 1;
        decim = 7;
        trig_edge = 0;
        trig_level = 100;
        ad_data = 50;
        do_reset();
        force_trig = 1;
        tick();
        force_trig = 0;
        repeat (10) tick();
        checks++;
        if (bz[1] !== 1'b0 || obs_q.size() !== 0) begin
            errors++;
            $display("FAIL force_idle: got busy=%b writes=%0d expected 0,0", bz[1], obs_q.size());
        end
        do_reset();
        r = cyc;
        do_arm();
        while (cyc < r + 80) begin
            force_trig = cyc == r + 10;
            if (cyc == r + 13) begin
                checks++;
                if (tg[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL force_pending: got triggered=%b expected 0", tg[1]);
                end
            end
            if (cyc >= r + 15 && exp_q.size() < 8 && (cyc - r) % 8 == 7) exp_q.push_back(50);
            tick();
        end
        force_trig = 0;
        first_t = obs_t.size() > 0 ? obs_t[0] : 0;
        last_t = obs_t.size() > 0 ? obs_t[$] : 0;
        checks++;
        if (first_t !== r + 16) begin
            errors++;
            $display("FAIL force_first_time: got %0d expected %0d", first_t - r, 16);
        end
        checks++;
        if (obs_q.size() !== 8) begin
            errors++;
            $display("FAIL force_count: got %0d expected 8", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++;
            if (o !== exp_q.pop_front()) begin
                errors++;
                $display("FAIL force_data: got %0d expected 50", o);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_t !== last_t + 1) begin
            errors++;
            $display("FAIL force_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_t, last_t + 1);
        end
    endtask

    task automatic test_fifo_full();
        int o, e;
        sel = 1;
        decim = 0;
        trig_edge = 0;
        trig_level = 100;
        do_reset();
        do_arm();
        ad_data = 50;
        tick();
        for (int i = 0; i < 8; i++) begin
            ad_data = 8'(150 + i);
            fifo_full = i == 2 || i == 3;
            if (!fifo_full) exp_q.push_back(150 + i);
            tick();
            checks++;
            if (ov[1] !== (i >= 2)) begin
                errors++;
                $display("FAIL full_overflow_%0d: got %b expected %b", i, ov[1], i >= 2);
            end
            if (i == 2) begin
                checks++;
                if (we[1] !== 1'b0 || wd1 !== 8'd151) begin
                    errors++;
                    $display("FAIL full_hold: got en=%b data=%0d expected 0,151", we[1], wd1);
                end
            end
        end
        fifo_full = 0;
        tick();
        checks++;
        if (dn[1] !== 1'b1 || ov[1] !== 1'b1) begin
            errors++;
            $display("FAIL full_done_overflow: got done=%b ovf=%b expected 1,1", dn[1], ov[1]);
        end
        repeat (2) tick();
        checks++;
        if (obs_q.size() !== 6) begin
            errors++;
            $display("FAIL full_count: got %0d expected 6", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL full_data: got %0d expected %0d", o, e);
            end
        end
        do_arm();
        checks++;
        if (ov[1] !== 1'b0) begin
            errors++;
            $display("FAIL full_ovf_clear: got %b expected 0", ov[1]);
        end
    endtask

    task automatic test_reset_mid();
        int o, e;
        sel = 1;
        decim = 0;
        trig_edge = 0;
        trig_level = 100;
        do_reset();
        do_arm();
        ad_data = 50;
        tick();
        ad_data = 150;
        tick();
        ad_data = 151;
        tick();
        rst = 1;
        ad_data = 152;
        tick();
        rst = 0;
        checks++;
        if ({we[1], bz[1], tg[1], dn[1], ov[1]} !== 5'd0 || wd1 !== 8'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got flags=%b data=%0d expected 0", {we[1], bz[1], tg[1], dn[1], ov[1]}, wd1);
        end
        ad_data = 160;
        repeat (10) tick();
        checks++;
        if (obs_q.size() !== 2 || done_cnt !== 0) begin
            errors++;
            $display("FAIL midrst_aborted: got writes=%0d done=%0d expected 2,0", obs_q.size(), done_cnt);
        end
        clear_obs();
        do_arm();
        ad_data = 50;
        tick();
        for (int i = 0; i < 8; i++) begin
            ad_data = 8'(150 + i);
            exp_q.push_back(150 + i);
            tick();
        end
        repeat (3) tick();
        checks++;
        if (obs_q.size() !== 8 || done_cnt !== 1) begin
            errors++;
            $display("FAIL midrst_recapture: got writes=%0d done=%0d expected 8,1", obs_q.size(), done_cnt);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL midrst_data: got %0d expected %0d", o, e);
            end
        end
    endtask

    task automatic test_len1();
        int wt;
        sel = 2;
        decim = 0;
        trig_edge = 0;
        trig_level = 100;
        do_reset();
        do_arm();
        ad_data = 50;
        tick();
        ad_data = 150;
        tick();
        ad_data = 170;
        checks++;
        if (we[2] !== 1'b1 || bz[2] !== 1'b0) begin
            errors++;
            $display("FAIL len1_direct_done: got en=%b busy=%b expected 1,0", we[2], bz[2]);
        end
        repeat (3) tick();
        wt = obs_t.size() > 0 ? obs_t[0] : 0;
        checks++;
        if (obs_q.size() !== 1 || (obs_q.size() > 0 && obs_q[0] !== 150)) begin
            errors++;
            $display("FAIL len1_write: got %0d writes expected 1 of 150", obs_q.size());
        end
        checks++;
        if (done_cnt !== 1 || done_t !== wt + 1) begin
            errors++;
            $display("FAIL len1_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_t, wt + 1);
        end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_no_trigger();
        test_falling_decim();
        test_force();
        test_fifo_full();
        test_reset_mid();
        test_len1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
